// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the two-port memory arbiter: FSM encoding, port indices, default widths.
// Also holds the small helper used to turn a port index into a per-port mask.
package mem_arbiter_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam int PORT_IF  = 0;
    localparam int PORT_MEM = 1;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    function automatic logic [1:0] port_mask(input logic idx);
        port_mask = idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way picker: fixed priority to the load/store port, or alternation on contention.
// Zero latency; no backpressure, the caller decides when the result is used.
module rr_pick2 #(
    parameter bit RR_EN = 1'b0
) (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       grant_o
);

    always_comb begin
        grant_o = 1'b0;
        if (RR_EN && (req_i == 2'b11)) begin
            grant_o = ~last_i;
        end else if (req_i[1]) begin
            grant_o = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store ports onto one memory; latches the command and holds it until ack.
// Request-to-ack is 2 cycles minimum (one transaction per 3 cycles); stall_o holds each port until its ack.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int RR_EN   = 0,
    parameter int TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        req_i,
    input  logic [1:0]        we_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic [1:0]        ack_o,
    output logic [1:0]        err_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [1:0]        stall_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q,  last_d;
    logic              we_q,    we_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q,   err_d;
    logic [7:0]        cnt_q,   cnt_d;
    logic              pick;
    logic              busy;
    logic              resp;

    rr_pick2 #(
        .RR_EN (RR_EN != 0)
    ) u_pick (
        .req_i   (req_i),
        .last_i  (last_q),
        .grant_o (pick)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    owner_d = pick;
                    last_d  = pick;
                    we_d    = we_i[pick];
                    addr_d  = pick ? addr1_i  : addr0_i;
                    wdata_d = pick ? wdata1_i : wdata0_i;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 8'd1;
                // A memory ack in the timeout cycle still counts as a normal completion.
                if (mem_ack_i) begin
                    rdata_d = we_q ? '0 : mem_rdata_i;
                    state_d = RESP;
                end else if (cnt_q == TO_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                cnt_d   = '0;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == BUSY);
    assign resp = (state_q == RESP);

    // Outputs decode straight from state so an async reset drops the memory command at once.
    assign mem_en_o    = busy;
    assign mem_we_o    = busy & we_q;
    assign mem_addr_o  = busy ? addr_q  : '0;
    assign mem_wdata_o = busy ? wdata_q : '0;

    assign ack_o   = resp ? port_mask(owner_q) : 2'b00;
    assign err_o   = (resp && err_q) ? port_mask(owner_q) : 2'b00;
    assign rdata_o = resp ? rdata_q : '0;
    assign stall_o = req_i & ~ack_o;

endmodule
